// File: rtl/alu_iter_muldiv.sv
// Execute-stage ALU: single-cycle integer ops plus iterative shift-add MUL and
// restoring DIVU/REMU, with a valid/ready handshake and flush for branch redirects.
module alu_iter_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic [CTRL_WIDTH-1:0] ALUctrlE,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] ALUout,
    output logic                  ZeroE
);
    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [SW:0] CNT_INIT = (SW+1)'(DATA_WIDTH - 1);
    localparam logic [SW:0] CNT_LAST = (SW+1)'(1);

    localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(3);
    localparam logic [CTRL_WIDTH-1:0] OP_XOR  = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] OP_SLT  = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] OP_SLL  = CTRL_WIDTH'(6);
    localparam logic [CTRL_WIDTH-1:0] OP_SRL  = CTRL_WIDTH'(7);
    localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(8);
    localparam logic [CTRL_WIDTH-1:0] OP_SLTU = CTRL_WIDTH'(9);
    localparam logic [CTRL_WIDTH-1:0] OP_MUL  = CTRL_WIDTH'(10);
    localparam logic [CTRL_WIDTH-1:0] OP_DIVU = CTRL_WIDTH'(11);
    localparam logic [CTRL_WIDTH-1:0] OP_REMU = CTRL_WIDTH'(12);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t                  state;
    logic [SW:0]             counter;
    logic [DATA_WIDTH-1:0]   acc, mcand, mplier;
    logic [DATA_WIDTH-1:0]   rem, quo, divisor;
    logic                    is_rem, zero_hold;
    logic [DATA_WIDTH-1:0]   single_res, acc_next, rem_next, quo_next, rem_first, quo_first;
    logic [SW-1:0]           shamt;
    logic                    accept, equal;

    // One restoring-division step: returns {remainder, quotient} after shifting in one bit.
    function automatic logic [2*DATA_WIDTH-1:0] div_step(
        input logic [DATA_WIDTH-1:0] r,
        input logic [DATA_WIDTH-1:0] q,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [DATA_WIDTH:0] trial;
        logic [DATA_WIDTH:0] diff;
        trial = {r, q[DATA_WIDTH-1]};
        diff  = trial - {1'b0, d};
        if (diff[DATA_WIDTH])
            return {trial[DATA_WIDTH-1:0], q[DATA_WIDTH-2:0], 1'b0};
        else
            return {diff[DATA_WIDTH-1:0], q[DATA_WIDTH-2:0], 1'b1};
    endfunction

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready && !flush;
    assign equal    = (SrcAE == SrcBE);
    assign shamt    = SrcBE[SW-1:0];

    always_comb begin
        single_res = '0;
        case (ALUctrlE)
            OP_ADD:  single_res = SrcAE + SrcBE;
            OP_SUB:  single_res = SrcAE - SrcBE;
            OP_AND:  single_res = SrcAE & SrcBE;
            OP_OR:   single_res = SrcAE | SrcBE;
            OP_XOR:  single_res = SrcAE ^ SrcBE;
            OP_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcAE) < $signed(SrcBE)};
            OP_SLL:  single_res = SrcAE << shamt;
            OP_SRL:  single_res = SrcAE >> shamt;
            OP_SRA:  single_res = $unsigned($signed(SrcAE) >>> shamt);
            OP_SLTU: single_res = {{(DATA_WIDTH-1){1'b0}}, SrcAE < SrcBE};
            default: single_res = '0;
        endcase
    end

    // The first iteration runs on the accepting edge, so only DATA_WIDTH-1 busy cycles follow.
    always_comb begin
        acc_next               = acc + (mplier[0] ? mcand : '0);
        {rem_next, quo_next}   = div_step(rem, quo, divisor);
        {rem_first, quo_first} = div_step('0, SrcAE, SrcBE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            out_valid <= 1'b0;
            ALUout    <= '0;
            ZeroE     <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            is_rem    <= 1'b0;
            zero_hold <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            counter   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (ALUctrlE == OP_MUL) begin
                            state     <= MUL;
                            counter   <= CNT_INIT;
                            acc       <= SrcBE[0] ? SrcAE : '0;
                            mcand     <= SrcAE << 1;
                            mplier    <= SrcBE >> 1;
                            zero_hold <= equal;
                        end else if (ALUctrlE == OP_DIVU || ALUctrlE == OP_REMU) begin
                            state     <= DIV;
                            counter   <= CNT_INIT;
                            rem       <= rem_first;
                            quo       <= quo_first;
                            divisor   <= SrcBE;
                            is_rem    <= (ALUctrlE == OP_REMU);
                            zero_hold <= equal;
                        end else begin
                            out_valid <= 1'b1;
                            ALUout    <= single_res;
                            ZeroE     <= equal;
                        end
                    end
                end
                MUL: begin
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter - 1'b1;
                    if (counter == CNT_LAST) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        ALUout    <= acc_next;
                        ZeroE     <= zero_hold;
                    end
                end
                DIV: begin
                    rem     <= rem_next;
                    quo     <= quo_next;
                    counter <= counter - 1'b1;
                    if (counter == CNT_LAST) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        ALUout    <= is_rem ? rem_next : quo_next;
                        ZeroE     <= zero_hold;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iter_muldiv.sv
// Randomised bench for alu_iter_muldiv: an arithmetic reference model with completion
// times is checked every cycle, plus directed cases with hand-computed results.
module tb_alu_iter_muldiv;
    localparam int W = 32;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd6, OP_SRA = 4'd8,
                           OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_DIVU = 4'd11, OP_REMU = 4'd12;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid;
    logic          in_ready, out_valid, ZeroE;
    logic [W-1:0]  SrcAE, SrcBE, ALUout;
    logic [3:0]    ALUctrlE;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 0;

    // Reference model state: one pending multi-cycle result with its completion edge.
    int           cyc       = 0;
    bit           pend      = 0;
    int           done_cyc  = 0;
    logic [W-1:0] pend_res  = '0;
    logic         pend_zero = 1'b0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_out   = '0;
    logic         exp_zero  = 1'b0;

    alu_iter_muldiv #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUctrlE(ALUctrlE), .out_valid(out_valid),
        .ALUout(ALUout), .ZeroE(ZeroE)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] refOp(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return a << b[4:0];
            4'd7:  return a >> b[4:0];
            4'd8:  return $unsigned($signed(a) >>> b[4:0]);
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return a * b;
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual,
                     expected, $time);
        end
    endtask

    // Model: multi-cycle ops finish W-1 edges after the accepting edge, single-cycle ops at once.
    always @(posedge clk) begin
        bit was_busy;
        cyc++;
        if (rst) begin
            pend = 0; exp_valid = 0; exp_out = '0; exp_zero = 0;
        end else if (flush) begin
            pend = 0; exp_valid = 0;
        end else begin
            was_busy  = pend;
            exp_valid = 0;
            if (pend && cyc == done_cyc) begin
                exp_valid = 1; exp_out = pend_res; exp_zero = pend_zero; pend = 0;
            end
            if (in_valid && !was_busy) begin
                if (ALUctrlE inside {OP_MUL, OP_DIVU, OP_REMU}) begin
                    pend      = 1;
                    done_cyc  = cyc + W - 1;
                    pend_res  = refOp(ALUctrlE, SrcAE, SrcBE);
                    pend_zero = (SrcAE == SrcBE);
                end else begin
                    exp_valid = 1;
                    exp_out   = refOp(ALUctrlE, SrcAE, SrcBE);
                    exp_zero  = (SrcAE == SrcBE);
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (check_en) begin
            checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
            checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!pend && !rst)});
            checkOutput("ALUout", ALUout, exp_out);
            checkOutput("ZeroE", {31'b0, ZeroE}, {31'b0, exp_zero});
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        bit ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1; break; end
        end
        if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
        ALUctrlE = op; SrcAE = a; SrcBE = b; in_valid = 1;
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] lit, input logic zlit,
                         input int lit_lat);
        int lat = 0;
        applyStimulus(op, a, b);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 0;
            if (out_valid === 1'b1) begin lat = i; break; end
        end
        checkOutput({name, "_lat"}, 32'(lat), 32'(lit_lat));
        checkOutput(name, ALUout, lit);
        checkOutput({name, "_zero"}, {31'b0, ZeroE}, {31'b0, zlit});
    endtask

    initial begin
        logic [3:0]   b2b_op  [4] = '{OP_ADD, OP_SUB, OP_SRA, OP_SLTU};
        logic [W-1:0] b2b_a   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'd1};
        logic [W-1:0] b2b_b   [4] = '{32'd7, 32'd7, 32'd4, 32'hFFFF_FFFF};
        logic [W-1:0] b2b_res [4] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'd1};

        rst = 1; flush = 0; in_valid = 1; ALUctrlE = OP_ADD; SrcAE = 5; SrcBE = 7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_en = 1;
            checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("rst_ALUout", ALUout, 32'd0);
        end
        rst = 0; in_valid = 0;
        @(negedge clk);

        checkOutput("model_mul", refOp(OP_MUL, 32'hFFFF, 32'h10001), 32'hFFFF_FFFF);
        checkOutput("model_sra", refOp(OP_SRA, 32'h8000_0000, 32'd4), 32'hF800_0000);
        checkOutput("model_remu0", refOp(OP_REMU, 32'd9, 32'd0), 32'd9);

        for (int i = 0; i < 4; i++) begin
            ALUctrlE = b2b_op[i]; SrcAE = b2b_a[i]; SrcBE = b2b_b[i]; in_valid = 1;
            checkOutput("b2b_ready", {31'b0, in_ready}, 32'd1);
            @(negedge clk);
            checkOutput("b2b_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("b2b_result", ALUout, b2b_res[i]);
        end
        in_valid = 0;

        runOp("mul", OP_MUL, 32'hFFFF, 32'h10001, 32'hFFFF_FFFF, 1'b0, W);
        runOp("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, W);
        runOp("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, W);
        runOp("divu0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, W);
        runOp("remu0", OP_REMU, 32'd9, 32'd0, 32'd9, 1'b0, W);
        runOp("sll_mask", OP_SLL, 32'd1, 32'd33, 32'd2, 1'b0, 1);
        runOp("sub_eq", OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1);

        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        @(negedge clk) in_valid = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk) flush = 0;
        checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_ready", {31'b0, in_ready}, 32'd1);
        runOp("after_flush", OP_ADD, 32'd3, 32'd3, 32'd6, 1'b1, 1);

        @(negedge clk);
        flush = 1; in_valid = 1; ALUctrlE = OP_ADD; SrcAE = 1; SrcBE = 2;
        @(negedge clk) flush = 0; in_valid = 0;
        checkOutput("flush_idle_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_idle_hold", ALUout, 32'd6);

        applyStimulus(OP_MUL, 32'd3, 32'd5);
        for (int i = 0; i < W - 1; i++) begin
            @(negedge clk);
            in_valid = 0;
        end
        flush = 1;
        @(negedge clk) flush = 0;
        checkOutput("flush_last_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("flush_last_valid2", {31'b0, out_valid}, 32'd0);

        applyStimulus(OP_REMU, 32'd77, 32'd5);
        @(negedge clk) in_valid = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk) rst = 0;
        checkOutput("rst_mid_ALUout", ALUout, 32'd0);
        checkOutput("rst_mid_valid", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 2) != 0);
            ALUctrlE = 4'($urandom_range(0, 15));
            SrcAE    = $urandom;
            case ($urandom_range(0, 7))
                0:       SrcBE = '0;
                1:       SrcBE = SrcAE;
                2, 3:    SrcBE = 32'($urandom_range(1, 40));
                default: SrcBE = $urandom;
            endcase
            flush = ($urandom_range(0, 31) == 0);
            rst   = ($urandom_range(0, 127) == 0);
        end
        @(negedge clk);
        in_valid = 0; flush = 0; rst = 0;
        repeat (W + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
